// File: rtl/mult_share_ctrl.sv
// Round-robin sequencer sharing one slow combinational array multiplier among NREQ requesters.
// Operands are registered and held for MUL_CYCLES before the product is captured.

module mult_share_array #(
    parameter int N = 16,
    parameter int M = 16
) (
    input  logic [N-1:0]   a_i,
    input  logic [M-1:0]   b_i,
    output logic [N+M-1:0] p_o
);

    // Shift-and-add rows of partial products; each row ripples into the accumulated sum.
    always_comb begin
        p_o = '0;
        for (int j = 0; j < M; j++) begin
            if (b_i[j]) begin
                p_o = p_o + ((N+M)'(a_i) << j);
            end
        end
    end

endmodule

module mult_share_ctrl #(
    parameter int N          = 16,
    parameter int M          = 16,
    parameter int NREQ       = 4,
    parameter int ID_W       = 2,
    parameter int MUL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*M-1:0]   req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [N+M-1:0]      res_p,
    output logic [ID_W-1:0]     res_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N-1:0]      op_a_q, op_a_d;
    logic [M-1:0]      op_b_q, op_b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [N+M-1:0]    res_p_q, res_p_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;

    logic [N+M-1:0]    array_p;
    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     scan_sum;
    logic [ID_W:0]     id_inc;
    logic [N-1:0]      sel_a;
    logic [M-1:0]      sel_b;

    mult_share_array #(
        .N(N),
        .M(M)
    ) u_array (
        .a_i(op_a_q),
        .b_i(op_b_q),
        .p_o(array_p)
    );

    // Rotate the request vector so bit 0 is rr_ptr, then map the first hit back to a real index.
    always_comb begin
        req_dbl     = {req_valid, req_valid};
        req_rot     = NREQ'(req_dbl >> rr_ptr_q);
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_rot[k]) begin
                grant_found = 1'b1;
                scan_sum    = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (scan_sum >= (ID_W+1)'(NREQ)) begin
                    scan_sum = scan_sum - (ID_W+1)'(NREQ);
                end
                grant_idx = scan_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*M +: M];
            end
        end
        id_inc = {1'b0, id_q} + (ID_W+1)'(1);
        if (id_inc >= (ID_W+1)'(NREQ)) begin
            id_inc = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            id_q     <= '0;
            res_p_q  <= '0;
            res_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            id_q     <= id_d;
            res_p_q  <= res_p_d;
            res_id_q <= res_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        id_d     = id_q;
        res_p_d  = res_p_q;
        res_id_d = res_id_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    id_d    = grant_idx;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // Product is sampled only after the operands have settled for the full window.
                if (cnt_q == 4'(MUL_CYCLES - 1)) begin
                    res_p_d  = array_p;
                    res_id_d = id_q;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    rr_ptr_d = id_inc[ID_W-1:0];
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
        end
        res_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        res_p     = res_p_q;
        res_id    = res_id_q;
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: stimulus queues expected grants/results,
// a negedge monitor pops and compares whenever the DUT grants or hands off a result.

module tb_mult_share_ctrl;

    localparam int N          = 16;
    localparam int M          = 16;
    localparam int NREQ       = 4;
    localparam int ID_W       = 2;
    localparam int MUL_CYCLES = 4;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [N+M-1:0]  p;
    } res_t;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*M-1:0]   req_b;
    logic                res_valid;
    logic                res_ready;
    logic [N+M-1:0]      res_p;
    logic [ID_W-1:0]     res_id;
    logic                busy;

    int   tests;
    int   failures;
    int   grantCount;
    int   expGrant[$];
    res_t expRes[$];
    int   monGrant;
    res_t monRes;

    mult_share_ctrl #(
        .N(N), .M(M), .NREQ(NREQ), .ID_W(ID_W), .MUL_CYCLES(MUL_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_p(res_p),
        .res_id(res_id),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        failures++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic applyStimulus(input int idx, input logic [N-1:0] a, input logic [M-1:0] b);
        req_a[idx*N +: N] = a;
        req_b[idx*M +: M] = b;
        req_valid[idx]    = 1'b1;
    endtask

    task automatic pushExpected(input int id, input logic [N+M-1:0] p);
        res_t r;
        r.id = ID_W'(id);
        r.p  = p;
        expRes.push_back(r);
    endtask

    // Returns just after the edge on which grant number 'target' was accepted.
    task automatic waitGrants(input int target, input string name);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (grantCount >= target) begin
                #1;
                return;
            end
        end
        timeoutFail(name);
    endtask

    task automatic waitIdle(input string name);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy && expRes.size() == 0) return;
        end
        timeoutFail(name);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic issueOne(input int id, input logic [N-1:0] a, input logic [M-1:0] b,
                            input logic [N+M-1:0] p, input string name);
        int base;
        expGrant.push_back(id);
        pushExpected(id, p);
        @(posedge clk);
        #1;
        base = grantCount;
        applyStimulus(id, a, b);
        waitGrants(base + 1, name);
        req_valid[id] = 1'b0;
    endtask

    // Grant and result monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                grantCount++;
                if (expGrant.size() == 0) begin
                    checkOutput("unexpected_grant", 64'(req_ready), 64'd0);
                end else begin
                    monGrant = expGrant.pop_front();
                    checkOutput("grant_onehot", 64'(req_ready), 64'(1) << monGrant);
                end
            end
            if (res_valid && res_ready) begin
                if (expRes.size() == 0) begin
                    checkOutput("unexpected_result", 64'(res_p), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    monRes = expRes.pop_front();
                    checkOutput("res_id", 64'(res_id), 64'(monRes.id));
                    checkOutput("res_p", 64'(res_p), 64'(monRes.p));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int base;
        logic sawValid;

        tests      = 0;
        failures   = 0;
        grantCount = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        res_ready  = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_res_p", 64'(res_p), 64'd0);
        checkOutput("rst_res_id", 64'(res_id), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request from requester 2, with latency measured from the grant edge
        issueOne(2, 16'h0003, 16'h0005, 32'h0000_000F, "t1_grant");
        lat = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
        end
        checkOutput("t1_latency", 64'(lat), 64'(MUL_CYCLES + 1));
        waitIdle("t1_idle");

        // Full-width and zero operands
        issueOne(0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "t2_grant_ones");
        waitIdle("t2_idle_ones");
        issueOne(0, 16'h1234, 16'h0000, 32'h0000_0000, "t2_grant_zero");
        waitIdle("t2_idle_zero");

        // All four persistent requesters from a fresh pointer
        doReset();
        expGrant.push_back(0); pushExpected(0, 32'h10);
        expGrant.push_back(1); pushExpected(1, 32'h20);
        expGrant.push_back(2); pushExpected(2, 32'h30);
        expGrant.push_back(3); pushExpected(3, 32'h40);
        expGrant.push_back(0); pushExpected(0, 32'h10);
        @(posedge clk);
        #1;
        base = grantCount;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 16'(i + 1), 16'h0010);
        waitGrants(base + 5, "t3_grants");
        req_valid = '0;
        waitIdle("t3_idle");

        // Backpressure with requester 3 waiting behind requester 1
        expGrant.push_back(1); pushExpected(1, 32'd6);
        expGrant.push_back(3); pushExpected(3, 32'd20);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        base = grantCount;
        applyStimulus(1, 16'd2, 16'd3);
        applyStimulus(3, 16'd4, 16'd5);
        waitGrants(base + 1, "t4_grant1");
        req_valid[1] = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        for (int c = 0; c < 10; c++) begin
            checkOutput("t4_hold_valid", 64'(res_valid), 64'd1);
            checkOutput("t4_hold_p", 64'(res_p), 64'd6);
            checkOutput("t4_hold_id", 64'(res_id), 64'd1);
            checkOutput("t4_hold_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        waitGrants(base + 2, "t4_grant3");
        req_valid[3] = 1'b0;
        waitIdle("t4_idle");

        // Operands changed after the grant must not affect the product
        issueOne(1, 16'd7, 16'd9, 32'd63, "t5_grant");
        req_a[1*N +: N] = 16'hAAAA;
        req_b[1*M +: M] = 16'hBBBB;
        waitIdle("t5_idle");

        // Reset during counter=1 aborts the transaction and clears the pointer
        expGrant.push_back(2);
        @(posedge clk);
        #1;
        base = grantCount;
        applyStimulus(2, 16'd5, 16'd5);
        waitGrants(base + 1, "t6_grant");
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_res_valid", 64'(res_valid), 64'd0);
        checkOutput("t6_res_p", 64'(res_p), 64'd0);
        checkOutput("t6_res_id", 64'(res_id), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sawValid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid) sawValid = 1'b1;
        end
        checkOutput("t6_no_result", 64'(sawValid), 64'd0);
        expGrant.push_back(0);
        pushExpected(0, 32'd42);
        @(posedge clk);
        #1;
        base = grantCount;
        applyStimulus(0, 16'd6, 16'd7);
        applyStimulus(2, 16'd1, 16'd1);
        applyStimulus(3, 16'd2, 16'd2);
        waitGrants(base + 1, "t6_regrant");
        req_valid = '0;
        waitIdle("t6_idle");

        checkOutput("leftover_grants", 64'(expGrant.size()), 64'd0);
        checkOutput("leftover_results", 64'(expRes.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Sequencer/arbiter that shares one combinational N x M array multiplier (`array`) among NREQ requesters.
- Grants requesters round-robin and registers the winner's operands.
- Holds those operands stable for a fixed multicycle window, because the ripple-carry array is slow. It then captures the product and presents it with the requester ID on a valid/ready result port.
- Sits between client blocks and the single multiplier instance.

Parameters:
- N, 16, width of operand a (multiplicand).
- M, 16, width of operand b (multiplier).
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NREQ.
- MUL_CYCLES, 4, cycles the operand registers are held before the product is sampled (1..15).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request strobe.
- req_ready  output  NREQ  one-hot grant; high in the acceptance cycle only.
- req_a  input  NREQ*N  packed operands a; requester i at [i*N +: N].
- req_b  input  NREQ*M  packed operands b; requester i at [i*M +: M].
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_p  output  N+M  unsigned product a*b.
- res_id  output  ID_W  index of requester that owns res_p.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - State = IDLE; rr_ptr = 0; counter = 0.
  - req_ready = 0; res_valid = 0; res_p = 0; res_id = 0; busy = 0.
  - Operand registers = 0.
- Reset asserted mid-operation aborts the transaction. The in-flight result is discarded and no res_valid is issued for it.

FSM:
- IDLE
  - If any req_valid bit is set, select winner g: first set bit searching from rr_ptr upward, wrapping at NREQ-1 to 0.
  - req_ready[g] = 1 combinationally in this cycle, and only while in IDLE.
  - On the edge: capture req_a/req_b slice g into operand registers; latch g into id register; counter = 0; go MUL.
  - If no req_valid is set: stay in IDLE; req_ready = 0.
- MUL
  - Operand registers drive the `array` instance unchanged.
  - Counter increments each cycle.
  - When counter == MUL_CYCLES-1: capture multiplier output into res_p, drive res_id from the id register, go DONE.
  - req_ready = 0 throughout.
- DONE
  - res_valid = 1; res_p and res_id held stable.
  - On res_valid & res_ready: go IDLE, rr_ptr = (g+1) mod NREQ, res_valid deasserts next cycle.
  - No new grant is issued in the same cycle as the result handshake.

Latency and throughput:
- Grant edge to res_valid: MUL_CYCLES + 1 cycles.
- Peak throughput: one product per MUL_CYCLES + 2 cycles, assuming res_ready is held high.

Boundary conditions:
- Requester changes req_a/req_b after its grant: no effect; operands are registered.
- Requester holds req_valid after its grant: treated as a new request.
- Requester drops req_valid before it is granted: no transaction for that requester.
- Single persistent requester: served back-to-back.
- Multiple persistent requesters: served in strict rotation; no starvation.
- Any NREQ-1 other requesters are each served once before a given requester is served twice.
- res_ready held low: DONE persists indefinitely with outputs stable; no further grants.
- Arithmetic is unsigned and full width.
  - All-ones operands give (2^N-1)*(2^M-1) exactly; no truncation.
  - Zero operands give 0.
- req_valid bits at index >= NREQ do not exist.
- rr_ptr never holds a value >= NREQ.

Test Plan:
- Reset then single request: requester 2 requests a=0x0003, b=0x0005.
  - req_ready = 4'b0100 for one cycle.
  - MUL_CYCLES+1 cycles later: res_valid=1, res_p=0x0000000F, res_id=2.
- Full-width values: a=0xFFFF, b=0xFFFF from requester 0 -> res_p=0xFFFE0001.
  - Then a=0x1234, b=0x0000 -> res_p=0.
- All four requesters valid continuously (a=i+1, b=0x10 for requester i), res_ready=1.
  - Grants occur in order 0,1,2,3,0.
  - res_id follows the same sequence; res_p = 0x10, 0x20, 0x30, 0x40, 0x10.
- Backpressure: hold res_ready=0 for 10 cycles in DONE with a second requester waiting.
  - res_valid, res_p and res_id stay stable; req_ready stays 0.
  - Release res_ready: IDLE, then grant to the waiting requester.
- Operand change after grant: requester 1 grants with a=7, b=9, then its inputs are changed to a=0xAAAA, b=0xBBBB.
  - res_p = 63; res_id = 1.
- Reset mid-MUL: assert rst during counter=1 of a transaction.
  - Outputs return to reset values next cycle; no res_valid for the aborted operation.
  - rr_ptr = 0; requester 0 wins the next arbitration when several are valid.
